debounce_edge: RTL and testbench
================================

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive samples needed to accept a level change; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 16: debounce counter width.
REQ-003 Parameter EVT_W, default 16: event counter width.
REQ-004 Parameter RST_LEVEL, default 1: reset value of deb_out; matches the high reset level of the upstream synchronizer.
REQ-005 clk  input  1  clock; all logic on rising edge; single clock domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sync_in  input  1  synchronized level from the upstream two-flop synchronizer; no further metastability handling.
REQ-008 en  input  1  debounce enable.
REQ-009 clr  input  1  synchronous clear of evt_cnt and evt_ovf.
REQ-010 deb_out  output  1  debounced level, registered.
REQ-011 rise  output  1  one-cycle pulse on accepted 0->1 change.
REQ-012 fall  output  1  one-cycle pulse on accepted 1->0 change.
REQ-013 evt_cnt  output  EVT_W  count of accepted rising edges, saturating.
REQ-014 evt_ovf  output  1  sticky flag: a rise occurred while evt_cnt was all-ones.

Function
REQ-015 FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO; deb_out = 1 in IDLE_HI and CHK_LO, 0 otherwise.
REQ-016 IDLE_LO with sync_in=1 and en=1 -> CHK_HI, counter <= 1; IDLE_HI with sync_in=0 and en=1 -> CHK_LO, counter <= 1.
REQ-017 CHK_HI: sync_in=0 -> IDLE_LO, counter <= 0, no pulse (glitch rejected); sync_in=1 and counter < DEB_CYCLES -> counter +1.
REQ-018 CHK_HI: when the DEB_CYCLES-th consecutive 1 is sampled -> IDLE_HI, deb_out <= 1, rise <= 1 on the same edge, counter <= 0.
REQ-019 CHK_LO is the mirror of CHK_HI: the DEB_CYCLES-th consecutive 0 -> IDLE_LO, deb_out <= 0, fall <= 1.
REQ-020 DEB_CYCLES=1: the first sample at the new level causes the transition and pulse directly from IDLE_x; CHK_x is not entered.
REQ-021 Latency: deb_out and the pulse are visible after the DEB_CYCLES-th rising edge that samples the new level.
REQ-022 rise and fall are high for exactly one cycle and are never high together.
REQ-023 en=0: FSM returns to IDLE_HI or IDLE_LO matching the current deb_out, counter <= 0, no pulses; deb_out holds.
REQ-024 Counter never exceeds DEB_CYCLES; no wrap-around.
REQ-025 Each rise increments evt_cnt by 1; at all-ones evt_cnt holds and evt_ovf <= 1.
REQ-026 clr=1 -> evt_cnt <= 0, evt_ovf <= 0; clr and rise in the same cycle -> evt_cnt <= 1, evt_ovf <= 0.
REQ-027 clr does not affect the FSM, deb_out, rise or fall.

Reset
REQ-028 rst=1 at a clock edge -> deb_out <= RST_LEVEL; state <= IDLE_HI if RST_LEVEL=1, else IDLE_LO; counter <= 0; rise, fall <= 0; evt_cnt <= 0; evt_ovf <= 0.
REQ-029 rst overrides en, clr and sync_in; reset during CHK_x abandons the pending change with no pulse.
REQ-030 After reset with sync_in equal to RST_LEVEL, no rise or fall occurs.

Verification
REQ-031 DEB_CYCLES=4, rst 2 cycles, sync_in=1 held -> deb_out=1, rise=fall=0, evt_cnt=0 for 20 cycles.
REQ-032 sync_in=0 for 3 cycles, then 1 -> deb_out stays 1, fall never asserts, FSM returns to IDLE_HI.
REQ-033 sync_in=0 for 4 cycles -> fall=1 for one cycle after the 4th edge, deb_out=0; then sync_in=1 for 4 cycles -> rise one cycle, deb_out=1, evt_cnt=1.
REQ-034 EVT_W=2, 4 accepted rises -> evt_cnt=3, evt_ovf=1 after the 4th; then clr=1 -> evt_cnt=0, evt_ovf=0.
REQ-035 clr asserted on the same cycle as an accepted rise with evt_cnt=5 -> evt_cnt=1, evt_ovf=0.
REQ-036 rst asserted on the 3rd cycle of CHK_LO -> no fall, deb_out=1, all outputs at reset values.

Source files
------------

// File: rtl/debounce_edge.sv
// Debounces a synchronized level and reports accepted edges.
// Also keeps a saturating count of accepted rising edges.
module debounce_edge #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EVT_W      = 16,
    parameter bit          RST_LEVEL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             en,
    input  logic             clr,
    output logic             deb_out,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             evt_ovf
);

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } state_t;

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam bit               DIRECT = (DEB_CYCLES == 1);
    localparam state_t           RST_ST = RST_LEVEL ? IDLE_HI : IDLE_LO;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             acc_rise;
    logic             acc_fall;

    // The sample that completes the run of equal levels is accepted now.
    always_comb begin
        acc_rise = en && sync_in &&
                   ((state == IDLE_LO && DIRECT) ||
                    (state == CHK_HI && cnt == LAST));
        acc_fall = en && !sync_in &&
                   ((state == IDLE_HI && DIRECT) ||
                    (state == CHK_LO && cnt == LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RST_ST;
            deb_out <= RST_LEVEL;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= acc_rise;
            fall <= acc_fall;
            if (!en) begin
                state <= deb_out ? IDLE_HI : IDLE_LO;
                cnt   <= '0;
            end else if (acc_rise) begin
                state   <= IDLE_HI;
                deb_out <= 1'b1;
                cnt     <= '0;
            end else if (acc_fall) begin
                state   <= IDLE_LO;
                deb_out <= 1'b0;
                cnt     <= '0;
            end else begin
                unique case (state)
                    IDLE_LO: begin
                        if (sync_in) begin
                            state <= CHK_HI;
                            cnt   <= ONE;
                        end
                    end
                    IDLE_HI: begin
                        if (!sync_in) begin
                            state <= CHK_LO;
                            cnt   <= ONE;
                        end
                    end
                    CHK_HI: begin
                        if (!sync_in) begin
                            state <= IDLE_LO;
                            cnt   <= '0;
                        end else if (cnt < LAST) begin
                            cnt <= cnt + ONE;
                        end
                    end
                    CHK_LO: begin
                        if (sync_in) begin
                            state <= IDLE_HI;
                            cnt   <= '0;
                        end else if (cnt < LAST) begin
                            cnt <= cnt + ONE;
                        end
                    end
                endcase
            end
        end
    end

    // A clear that coincides with a rise still counts that rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt <= '0;
            evt_ovf <= 1'b0;
        end else if (clr) begin
            evt_cnt <= acc_rise ? EVT_W'(1) : '0;
            evt_ovf <= 1'b0;
        end else if (acc_rise) begin
            if (&evt_cnt) begin
                evt_ovf <= 1'b1;
            end else begin
                evt_cnt <= evt_cnt + EVT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: expected edge events are queued
// by the stimulus and popped by a monitor whenever a pulse appears.
module tb_debounce_edge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_in = 1'b1;
    logic en = 1'b1;
    logic clr = 1'b0;

    logic        d_deb, d_rise, d_fall, d_ovf;
    logic [15:0] d_cnt;
    logic        s_deb, s_rise, s_fall, s_ovf;
    logic [1:0]  s_cnt;
    logic        o_deb, o_rise, o_fall, o_ovf;
    logic [15:0] o_cnt;

    debounce_edge u_dut (
        .clk(clk), .rst(rst), .sync_in(sync_in), .en(en), .clr(clr),
        .deb_out(d_deb), .rise(d_rise), .fall(d_fall),
        .evt_cnt(d_cnt), .evt_ovf(d_ovf)
    );

    debounce_edge #(.EVT_W(2)) u_sat (
        .clk(clk), .rst(rst), .sync_in(sync_in), .en(en), .clr(clr),
        .deb_out(s_deb), .rise(s_rise), .fall(s_fall),
        .evt_cnt(s_cnt), .evt_ovf(s_ovf)
    );

    debounce_edge #(.DEB_CYCLES(1)) u_one (
        .clk(clk), .rst(rst), .sync_in(sync_in), .en(en), .clr(clr),
        .deb_out(o_deb), .rise(o_rise), .fall(o_fall),
        .evt_cnt(o_cnt), .evt_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_rise;
        int at;
        bit deb;
        int cnt;
        bit ovf;
        int scnt;
        bit sovf;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    int m_cnt = 0;
    bit m_ovf = 1'b0;
    int m_scnt = 0;
    bit m_sovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input bit r, input bit with_clr, input int lat);
        exp_t e;
        if (r) begin
            if (with_clr) begin
                m_cnt = 1; m_ovf = 1'b0;
                m_scnt = 1; m_sovf = 1'b0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_scnt == 3) m_sovf = 1'b1;
                else m_scnt = m_scnt + 1;
            end
        end
        e.is_rise = r;
        e.at = cyc + lat;
        e.deb = r;
        e.cnt = m_cnt;
        e.ovf = m_ovf;
        e.scnt = m_scnt;
        e.sovf = m_sovf;
        q.push_back(e);
    endtask

    task automatic accept(input bit r, input bit with_clr);
        push_evt(r, with_clr, 4);
        sync_in = r;
        if (with_clr) begin
            step(3);
            clr = 1'b1;
            step(1);
            clr = 1'b0;
            step(2);
        end else begin
            step(6);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        m_cnt = 0; m_ovf = 1'b0;
        m_scnt = 0; m_sovf = 1'b0;
    endtask

    // Monitor: every pulse on the main instance must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (d_rise && d_fall) chk("rise_fall_overlap", 1, 0);
        if (d_rise || d_fall) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", int'(d_rise), 2);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_dir", int'(d_rise), int'(e.is_rise));
                chk("pulse_deb", int'(d_deb), int'(e.deb));
                chk("pulse_evt_cnt", int'(d_cnt), e.cnt);
                chk("pulse_evt_ovf", int'(d_ovf), int'(e.ovf));
                chk("pulse_sat_cnt", int'(s_cnt), e.scnt);
                chk("pulse_sat_ovf", int'(s_ovf), int'(e.sovf));
            end
        end
    end

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_deb", int'(d_deb), 1);
        chk("rst_rise", int'(d_rise), 0);
        chk("rst_fall", int'(d_fall), 0);
        chk("rst_evt_cnt", int'(d_cnt), 0);
        chk("rst_evt_ovf", int'(d_ovf), 0);
        chk("rst_sat_cnt", int'(s_cnt), 0);
        chk("rst_one_deb", int'(o_deb), 1);

        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("hold_deb", int'(d_deb), 1);
            chk("hold_evt_cnt", int'(d_cnt), 0);
        end

        sync_in = 1'b0;
        step(3);
        sync_in = 1'b1;
        step(6);
        chk("glitch_deb", int'(d_deb), 1);

        push_evt(1'b0, 1'b0, 4);
        sync_in = 1'b0;
        step(1);
        chk("one_fall", int'(o_fall), 1);
        chk("one_fall_deb", int'(o_deb), 0);
        step(1);
        chk("one_fall_width", int'(o_fall), 0);
        step(4);
        chk("fall_deb", int'(d_deb), 0);

        push_evt(1'b1, 1'b0, 4);
        sync_in = 1'b1;
        step(1);
        chk("one_rise", int'(o_rise), 1);
        step(5);
        chk("rise_deb", int'(d_deb), 1);
        chk("rise_evt_cnt", int'(d_cnt), 1);

        for (int i = 0; i < 3; i++) begin
            accept(1'b0, 1'b0);
            accept(1'b1, 1'b0);
        end
        chk("sat_cnt", int'(s_cnt), 3);
        chk("sat_ovf", int'(s_ovf), 1);
        chk("main_cnt4", int'(d_cnt), 4);
        do_clr();
        chk("clr_sat_cnt", int'(s_cnt), 0);
        chk("clr_sat_ovf", int'(s_ovf), 0);
        chk("clr_main_cnt", int'(d_cnt), 0);
        chk("clr_deb", int'(d_deb), 1);

        sync_in = 1'b0;
        step(2);
        en = 1'b0;
        step(1);
        chk("en_off_deb", int'(d_deb), 1);
        en = 1'b1;
        push_evt(1'b0, 1'b0, 4);
        step(6);
        chk("en_restart_deb", int'(d_deb), 0);
        accept(1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            accept(1'b0, 1'b0);
            accept(1'b1, 1'b0);
        end
        chk("main_cnt5", int'(d_cnt), 5);
        accept(1'b0, 1'b0);
        accept(1'b1, 1'b1);
        chk("clr_rise_cnt", int'(d_cnt), 1);
        chk("clr_rise_ovf", int'(d_ovf), 0);
        chk("clr_rise_sat", int'(s_cnt), 1);
        chk("clr_rise_sat_ovf", int'(s_ovf), 0);

        sync_in = 1'b0;
        step(3);
        rst = 1'b1;
        sync_in = 1'b1;
        step(1);
        rst = 1'b0;
        m_cnt = 0; m_ovf = 1'b0;
        m_scnt = 0; m_sovf = 1'b0;
        chk("mid_rst_deb", int'(d_deb), 1);
        chk("mid_rst_rise", int'(d_rise), 0);
        chk("mid_rst_fall", int'(d_fall), 0);
        chk("mid_rst_cnt", int'(d_cnt), 0);
        chk("mid_rst_ovf", int'(d_ovf), 0);
        step(10);
        chk("post_rst_deb", int'(d_deb), 1);

        for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
